// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle control FSM FETCH/EXEC/[MUL]/WB (optional MUL path: CTRL_MUL_EN)
module controle_multiciclo #(
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            zero,
  output logic            EscIR,
  output logic            EscCP,
  output logic            EscCondCP,
  output logic [OP_W-1:0] ULA_OP,
  output logic            ULA_A,
  output logic [1:0]      ULA_B,
  output logic [1:0]      FonteCP,
  output logic            EscReg,
  output logic            flagimm,
  output logic            mul,
  output logic            busy,
  output logic            illegal
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] op_lo;
  logic       op_hi_nz;
  logic       is_r, is_i, is_j, is_b, is_m, is_ill;
  logic       mul_done;
  logic       wb_we;

  assign op_lo    = opcode[3:0];
  assign op_hi_nz = |(opcode >> 4);
  assign ULA_OP   = opcode;

  // Opcode class decode; anything with high bits set is illegal
  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_j   = 1'b0;
    is_b   = 1'b0;
    is_m   = 1'b0;
    is_ill = 1'b0;
    if (op_hi_nz) begin
      is_ill = 1'b1;
    end else begin
      case (op_lo)
        4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd13, 4'd14: is_r = 1'b1;
        4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:        is_i = 1'b1;
        4'd11:                                       is_j = 1'b1;
        4'd12:                                       is_b = 1'b1;
`ifdef CTRL_MUL_EN
        default:                                     is_m = 1'b1;
`else
        default:                                     is_ill = 1'b1;
`endif
      endcase
    end
  end

`ifdef CTRL_MUL_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign mul_done = (cnt == MUL_LAST);

  // Multiply cycle counter: cleared when leaving EXEC, counts in MUL, frozen by stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!stall) begin
      if (state == EXEC) begin
        cnt <= '0;
      end else if (state == MUL) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  logic mul_cfg_unused;

  assign mul_done       = 1'b1;
  assign mul_cfg_unused = (MUL_CYCLES > CNT_W);
`endif

  // Next-state logic; stall holds the current state
  always_comb begin
    state_nxt = state;
    if (!stall) begin
      case (state)
        FETCH:   if (imem_ready) state_nxt = EXEC;
        EXEC:    state_nxt = is_m ? MUL : WB;
        MUL:     if (mul_done) state_nxt = WB;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  assign wb_we = (state == WB) && !stall;

  // Output decode; reset forces everything low, stall only masks the write enables
  always_comb begin
    EscIR     = 1'b0;
    EscCP     = 1'b0;
    EscCondCP = 1'b0;
    ULA_A     = 1'b0;
    ULA_B     = 2'b00;
    FonteCP   = 2'b00;
    EscReg    = 1'b0;
    flagimm   = 1'b0;
    mul       = 1'b0;
    busy      = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      busy = (state != FETCH);
      if (state == FETCH) begin
        EscIR = imem_ready & ~stall;
      end else begin
        // Operand selects are set in EXEC and held unchanged until WB ends
        if (is_r || is_m) begin
          ULA_A = 1'b1;
        end
        if (is_i) begin
          ULA_A   = 1'b1;
          ULA_B   = 2'b10;
          flagimm = 1'b1;
        end
        case (state)
          EXEC: begin
            if (is_j) FonteCP = 2'b10;
            if (is_b) FonteCP = 2'b01;
`ifdef CTRL_MUL_EN
            mul = is_m;
`endif
          end
          MUL: begin
`ifdef CTRL_MUL_EN
            mul = 1'b1;
`endif
          end
          default: begin
            if (is_j) begin
              FonteCP = 2'b10;
            end else if (is_b && zero) begin
              FonteCP = 2'b01;
            end
            EscCP     = wb_we;
            EscReg    = wb_we & (is_r | is_i | is_m);
            EscCondCP = wb_we & is_b;
            illegal   = wb_we & is_ill;
          end
        endcase
      end
    end
  end

endmodule
